// File: rtl/otter_rfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : otter_rfile_sb
//  Purpose  : OTTER integer register file with two combinational read ports,
//             one synchronous write port and a per-register pending-write
//             scoreboard (issue sets, writeback clears, issue wins on a tie).
//             Exposes per-source busy flags, a WAW indication and a
//             registered pending-register count.
//  Options  : OTTER_RFILE_BYPASS_EN - write-through forwarding of the
//             writeback port onto the read ports and busy flags.
//  Revision : 1.0 - initial release
// ============================================================================
module otter_rfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   r_addr1,
    input  logic [AW-1:0]   r_addr2,
    output logic [XLEN-1:0] r_rs1,
    output logic [XLEN-1:0] r_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            w_en,
    input  logic [AW-1:0]   w_addr,
    input  logic [XLEN-1:0] w_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic            iss_waw,
    output logic [AW:0]     pend_cnt
);

    localparam logic [AW-1:0] c_x0 = '0;

    logic [XLEN-1:0] rfile_q [NREGS];
    logic [XLEN-1:0] rfile_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    logic             w_wr_ok;
    logic             w_iss_ok;

    assign w_wr_ok  = w_en   && (w_addr   != c_x0);
    assign w_iss_ok = iss_en && (iss_addr != c_x0);

    // Next-state register contents: one write per cycle, x0 stays zero.
    always_comb begin
        rfile_d = rfile_q;
        if (w_wr_ok) begin
            rfile_d[w_addr] = w_data;
        end
        rfile_d[0] = '0;
    end

    // Next-state scoreboard: writeback clears, a same-cycle issue re-sets
    // the bit because the newer producer still has to write back.
    always_comb begin
        pend_d = pend_q;
        if (w_wr_ok) begin
            pend_d[w_addr] = 1'b0;
        end
        if (w_iss_ok) begin
            pend_d[iss_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Population count of the next-state pending vector.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
        end
    end

    // State registers; reset clears data, scoreboard and count immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rfile_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            rfile_q <= rfile_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read port 1: registered data and busy, optionally forwarded from writeback.
    always_comb begin
        r_rs1    = rfile_q[r_addr1];
        rs1_busy = pend_q[r_addr1];
`ifdef OTTER_RFILE_BYPASS_EN
        if (w_wr_ok && (r_addr1 == w_addr)) begin
            r_rs1    = w_data;
            rs1_busy = iss_en && (iss_addr == w_addr);
        end
`endif
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        r_rs2    = rfile_q[r_addr2];
        rs2_busy = pend_q[r_addr2];
`ifdef OTTER_RFILE_BYPASS_EN
        if (w_wr_ok && (r_addr2 == w_addr)) begin
            r_rs2    = w_data;
            rs2_busy = iss_en && (iss_addr == w_addr);
        end
`endif
    end

    assign iss_waw  = w_iss_ok && pend_q[iss_addr];
    assign pend_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_otter_rfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_otter_rfile_sb
//  Purpose  : Scoreboard bench for otter_rfile_sb. A stimulus process drives
//             directed and random cycles and pushes the expected outputs of
//             an array-based reference model; a monitor pops and compares at
//             each falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_otter_rfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   r_addr1, r_addr2;
    logic [XLEN-1:0] r_rs1, r_rs2;
    logic            rs1_busy, rs2_busy;
    logic            w_en;
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            iss_waw;
    logic [AW:0]     pend_cnt;

    otter_rfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .r_addr1(r_addr1), .r_addr2(r_addr2),
        .r_rs1(r_rs1), .r_rs2(r_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_waw(iss_waw), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            b1;
        logic            b2;
        logic            waw;
        logic [AW:0]     cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Apply the inputs present at the rising edge to the model.
    task automatic model_commit();
        if (w_en && w_addr != 0) begin
            m_regs[w_addr] = w_data;
            m_pend[w_addr] = 1'b0;
        end
        if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    endtask

    function automatic void read_port(input logic [AW-1:0] a,
                                      output logic [XLEN-1:0] d, output logic b);
        d = (a == 0) ? '0 : m_regs[a];
        b = (a == 0) ? 1'b0 : m_pend[a];
`ifdef OTTER_RFILE_BYPASS_EN
        if (w_en && w_addr != 0 && a == w_addr) begin
            d = w_data;
            b = iss_en && (iss_addr == w_addr);
        end
`endif
    endfunction

    task automatic push_expected();
        exp_t e;
        int   n;
        read_port(r_addr1, e.rs1, e.b1);
        read_port(r_addr2, e.rs2, e.b2);
        e.waw = iss_en && (iss_addr != 0) && m_pend[iss_addr];
        n = 0;
        for (int i = 1; i < NREGS; i++) n += int'(m_pend[i]);
        e.cnt = n[AW:0];
        exp_q.push_back(e);
    endtask

    // One clock cycle: commit the previous inputs, apply new ones, predict.
    task automatic drive(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic we, input logic [AW-1:0] wa,
                         input logic [XLEN-1:0] wd,
                         input logic ie, input logic [AW-1:0] ia);
        @(posedge clk);
        if (rst_n) model_commit();
        #1;
        r_addr1 = a1; r_addr2 = a2;
        w_en = we; w_addr = wa; w_data = wd;
        iss_en = ie; iss_addr = ia;
        push_expected();
    endtask

    // Assert reset between edges, check while it is low, release before next edge.
    task automatic pulse_reset(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(posedge clk);
        if (rst_n) model_commit();
        #1;
        rst_n = 1'b0;
        model_reset();
        r_addr1 = a1; r_addr2 = a2;
        w_en = 1'b0; iss_en = 1'b0; w_addr = '0; iss_addr = '0; w_data = '0;
        push_expected();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("r_rs1",    r_rs1,                    e.rs1);
                chk("r_rs2",    r_rs2,                    e.rs2);
                chk("rs1_busy", {31'd0, rs1_busy},        {31'd0, e.b1});
                chk("rs2_busy", {31'd0, rs2_busy},        {31'd0, e.b2});
                chk("iss_waw",  {31'd0, iss_waw},         {31'd0, e.waw});
                chk("pend_cnt", {{(XLEN-AW-1){1'b0}}, pend_cnt},
                                {{(XLEN-AW-1){1'b0}}, e.cnt});
            end
        end
    end

    // Stimulus.
    initial begin
        int drain;
        rst_n = 1'b0;
        r_addr1 = '0; r_addr2 = '0;
        w_en = 1'b0; w_addr = '0; w_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        model_reset();

        // Reset held for two cycles, then released between edges.
        drive(5'd5, 5'd31, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        drive(5'd5, 5'd31, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(5'd5, 5'd31, 1'b0, 5'd0, '0, 1'b0, 5'd0);

        // x0 protection.
        drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);

        // Issue / writeback lifecycle on x7.
        drive(5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
        drive(5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        drive(5'd7, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        drive(5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0);

        // Simultaneous issue and writeback on pending x3.
        drive(5'd0, 5'd3, 1'b0, 5'd0, '0, 1'b1, 5'd3);
        drive(5'd0, 5'd3, 1'b1, 5'd3, 32'hA5, 1'b1, 5'd3);
        drive(5'd3, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);

        // WAW and count: clear x3, issue x1..x3, re-issue x2.
        drive(5'd0, 5'd3, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
        drive(5'd1, 5'd2, 1'b0, 5'd0, '0, 1'b1, 5'd1);
        drive(5'd1, 5'd2, 1'b0, 5'd0, '0, 1'b1, 5'd2);
        drive(5'd1, 5'd3, 1'b0, 5'd0, '0, 1'b1, 5'd3);
        drive(5'd2, 5'd3, 1'b0, 5'd0, '0, 1'b1, 5'd2);
        drive(5'd2, 5'd2, 1'b0, 5'd0, '0, 1'b0, 5'd0);

        // Asynchronous reset with x4 written and pending.
        drive(5'd4, 5'd0, 1'b1, 5'd4, 32'hFF, 1'b1, 5'd4);
        drive(5'd4, 5'd4, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        pulse_reset(5'd4, 5'd4);
        drive(5'd4, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0);

        // Random traffic concentrated on a few registers to force collisions.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a1, a2, wa, ia;
            a1 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            wa = AW'($urandom_range(0, 7));
            ia = AW'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0)
                pulse_reset(a1, a2);
            else
                drive(a1, a2, 1'($urandom_range(0, 1)), wa, $urandom,
                      1'($urandom_range(0, 1)), ia);
        end
        drive(5'd1, 5'd2, 1'b0, 5'd0, '0, 1'b0, 5'd0);

        // Drain the scoreboard within a bounded number of cycles.
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
